// File: rtl/common.sv
// Shared PS/2 types: the command byte and the host-to-device transmitter state encoding.
package common;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    DATA,
    PARITY,
    STOP,
    ACK
  } ps2_tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge detector on the clock.
module ps2_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ps2_clk_async_i,
  input  logic ps2_data_async_i,
  output logic ps2_clk_o,
  output logic ps2_data_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_async_i};
    data_sync_d = {data_sync_q[0], ps2_data_async_i};
    clk_prev_d  = clk_sync_q[1];
  end

  // Idle bus level is high, so resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign ps2_clk_o  = clk_sync_q[1];
  assign ps2_data_o = data_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits LSB-first, odd parity, stop, ACK.
module ps2_tx
  import common::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  ps2_clk_async_i,
  input  logic  ps2_data_async_i,
  output logic  ps2_clk_oe_o,
  output logic  ps2_data_oe_o,
  input  byte_t data_i,
  input  logic  valid_i,
  output logic  ready_o,
  output logic  done_o,
  output logic  error_o
);

  localparam int CNT_W = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic ps2_clk_sync, ps2_data_sync, clk_fall;

  ps2_sync u_sync (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .ps2_clk_async_i  (ps2_clk_async_i),
    .ps2_data_async_i (ps2_data_async_i),
    .ps2_clk_o        (ps2_clk_sync),
    .ps2_data_o       (ps2_data_sync),
    .clk_fall_o       (clk_fall)
  );

  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  byte_t            shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (valid_i) begin
          shift_d   = data_i;
          parity_d  = ~^data_i;
          cnt_d     = '0;
          bit_idx_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = REQUEST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // REQUEST..ACK: the device clocks the bus; every falling edge advances one bit.
      default: begin
        if (clk_fall) begin
          cnt_d = '0;
          case (state_q)
            REQUEST: begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
              bit_idx_d = 4'd1;
              state_d   = DATA;
            end
            DATA: begin
              if (bit_idx_q == 4'd8) begin
                data_oe_d = ~parity_q;
                state_d   = PARITY;
              end else begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b0, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 4'd1;
              end
            end
            PARITY: begin
              data_oe_d = 1'b0;
              state_d   = STOP;
            end
            STOP: state_d = ACK;
            ACK: begin
              if (ps2_data_sync) error_d = 1'b1;
              else               done_d  = 1'b1;
              state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else if (cnt_q == TIMEOUT_LAST) begin
          error_d   = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // The synced clock level itself is not needed by the transmitter, only its falling edge.
  logic unused_clk_level;
  assign unused_clk_level = ps2_clk_sync;

  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  assign ready_o       = (state_q == IDLE);
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out, scoreboard queues hold expected frames and outcomes.
module tb_ps2_tx;
  import common::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 8;
  localparam int XFER_BOUND = 800;

  logic  clk = 1'b0;
  logic  rst;
  logic  dev_clk, dev_data;
  logic  ps2_clk_line, ps2_data_line;
  logic  clk_oe, data_oe;
  byte_t data_in;
  logic  valid, ready, done, error;

  int tests_run = 0;
  int fails = 0;

  logic [10:0] exp_frames[$];
  int          exp_outcomes[$];   // 1 = done, 2 = error

  int   cyc = 0;
  int   done_total = 0, err_total = 0, both_cnt = 0;
  int   inh_run = 0, last_inh = 0, doe_run = 0, last_doe = 0;
  int   done_cyc = -1, inh_start_cyc = -1;
  logic clk_oe_prev = 1'b0;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_line  = dev_clk & ~clk_oe;
  assign ps2_data_line = dev_data & ~data_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .ps2_clk_async_i  (ps2_clk_line),
    .ps2_data_async_i (ps2_data_line),
    .ps2_clk_oe_o     (clk_oe),
    .ps2_data_oe_o    (data_oe),
    .data_i           (data_in),
    .valid_i          (valid),
    .ready_o          (ready),
    .done_o           (done),
    .error_o          (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (done) begin done_total++; done_cyc = cyc; end
    if (error) err_total++;
    if (done && error) both_cnt++;
    if (clk_oe) inh_run++;
    else begin if (inh_run != 0) last_inh = inh_run; inh_run = 0; end
    if (data_oe) doe_run++;
    else begin if (doe_run != 0) last_doe = doe_run; doe_run = 0; end
    if (clk_oe && !clk_oe_prev) inh_start_cyc = cyc;
    clk_oe_prev = clk_oe;
  end

  task automatic send_byte(input byte_t b, input int outcome, input bit push_frame);
    @(negedge clk);
    data_in = b;
    valid   = 1'b1;
    tests_run++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_send: got %b expected 1 (byte %02h)", ready, b);
    end
    if (push_frame) exp_frames.push_back({1'b1, ~^b, b, 1'b0});
    if (outcome != 0) exp_outcomes.push_back(outcome);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, then issues npulses clock pulses, sampling on rising edges.
  task automatic run_device(input int npulses, input logic ack_bit);
    logic [10:0] frame;
    logic [10:0] expf;
    bit seen;
    frame = '0;
    seen  = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge clk);
      if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      tests_run++;
      fails++;
      $display("FAIL request_to_send: no request seen within %0d cycles", INH + 50);
      if (npulses == 12 && exp_frames.size() != 0) void'(exp_frames.pop_front());
      return;
    end
    frame[0] = ps2_data_line;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= npulses; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = ps2_data_line;
      if (k == 10) dev_data = ack_bit;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
    if (npulses == 12) begin
      expf = (exp_frames.size() != 0) ? exp_frames.pop_front() : 11'h7FF;
      tests_run++;
      if (frame !== expf) begin
        fails++;
        $display("FAIL frame: got %b expected %b (stop,parity,d7..d0,start)", frame, expf);
      end else begin
        $display("[TB] frame %b received", frame);
      end
    end
  endtask

  task automatic wait_outcome(input string name, input int bound);
    int  expv, obs;
    bit  got;
    got = 1'b0;
    obs = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || error) begin got = 1'b1; obs = done ? 1 : 2; break; end
    end
    expv = (exp_outcomes.size() != 0) ? exp_outcomes.pop_front() : 0;
    tests_run++;
    if (!got || obs != expv) begin
      fails++;
      $display("FAIL %s outcome: got %0d expected %0d (0=none 1=done 2=error)", name, obs, expv);
    end else begin
      $display("[TB] %s outcome %0d", name, obs);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse_width: done=%b error=%b expected both 0 one cycle later", name, done, error);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || clk_oe !== 1'b0 || data_oe !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%b clk_oe=%b data_oe=%b done=%b error=%b expected 1 0 0 0 0",
               ready, clk_oe, data_oe, done, error);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: ready=%b clk_oe=%b data_oe=%b expected 1 0 0", ready, clk_oe, data_oe);
    end
  endtask

  task automatic test_ack_f4();
    send_byte(8'hF4, 1, 1'b1);
    fork
      run_device(12, 1'b0);
      wait_outcome("f4", XFER_BOUND);
    join
    #1;
    tests_run++;
    if (ready !== 1'b1 || done_total != 1 || err_total != 0) begin
      fails++;
      $display("FAIL f4_after: ready=%b done_total=%0d err_total=%0d expected 1 1 0", ready, done_total, err_total);
    end
  endtask

  task automatic test_ed_inhibit();
    send_byte(8'hED, 1, 1'b1);
    fork
      run_device(12, 1'b0);
      wait_outcome("ed", XFER_BOUND);
    join
    #1;
    tests_run++;
    if (last_inh != INH) begin
      fails++;
      $display("FAIL inhibit_len: got %0d cycles expected %0d", last_inh, INH);
    end
  endtask

  task automatic test_nack();
    int d0;
    d0 = done_total;
    send_byte(8'h00, 2, 1'b1);
    fork
      run_device(12, 1'b1);
      wait_outcome("nack", XFER_BOUND);
    join
    #1;
    tests_run++;
    if (done_total != d0) begin
      fails++;
      $display("FAIL nack_no_done: done_total=%0d expected %0d", done_total, d0);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hFF, 2, 1'b0);
    wait_outcome("timeout", INH + TMO + 50);
    #1;
    tests_run++;
    if (last_doe != TMO) begin
      fails++;
      $display("FAIL timeout_len: request lasted %0d cycles expected %0d", last_doe, TMO);
    end
    tests_run++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_release: clk_oe=%b data_oe=%b ready=%b expected 0 0 1", clk_oe, data_oe, ready);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send_byte(8'h4A, 0, 1'b0);
    run_device(5, 1'b0);
    tests_run++;
    if (data_oe !== 1'b1) begin
      fails++;
      $display("FAIL bit4_driven: data_oe=%b expected 1 (bit4 of 4A is 0)", data_oe);
    end
    d0 = done_total;
    e0 = err_total;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: clk_oe=%b data_oe=%b ready=%b done=%b error=%b expected 0 0 1 0 0",
               clk_oe, data_oe, ready, done, error);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    tests_run++;
    if (done_total != d0 || err_total != e0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_pulse: done_total=%0d err_total=%0d ready=%b expected %0d %0d 1",
               done_total, err_total, ready, d0, e0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data_in = 8'h3C;
    valid   = 1'b1;
    exp_frames.push_back({1'b1, ~^data_in, data_in, 1'b0});
    exp_outcomes.push_back(1);
    @(negedge clk);
    data_in = 8'hA5;
    exp_frames.push_back({1'b1, ~^data_in, data_in, 1'b0});
    exp_outcomes.push_back(1);
    fork
      run_device(12, 1'b0);
      wait_outcome("b2b_first", XFER_BOUND);
    join
    #1;
    tests_run++;
    if (inh_start_cyc != done_cyc + 1) begin
      fails++;
      $display("FAIL b2b_accept: second inhibit began cycle %0d expected %0d", inh_start_cyc, done_cyc + 1);
    end
    @(negedge clk);
    valid = 1'b0;
    fork
      run_device(12, 1'b0);
      wait_outcome("b2b_second", XFER_BOUND);
    join
  endtask

  initial begin
    rst      = 1'b1;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    valid    = 1'b0;
    data_in  = '0;
    test_reset();
    test_ack_f4();
    test_ed_inhibit();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (both_cnt != 0) begin
      fails++;
      $display("FAIL done_error_overlap: %0d cycles with both high expected 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
